// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding and ALU op codes.
// The op codes match funct3[1:0] of the RISC-V M-extension divide group.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // DIV and REM are the signed flavours (funct3[0] clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div32_seq_if.sv
// Request/response bundle between the issuing core and the divider.
interface div32_seq_if #(parameter int N = 32);

  logic         in_valid;
  logic         in_ready;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         div_zero;

  modport master (
    output in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, quo, rem, div_zero
  );

  modport slave (
    input  in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, quo, rem, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit if it
// did not go negative.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] d,
  output logic [N:0]   r_out,
  output logic [N-1:0] q_out
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  assign shifted = {r_in, q_in[N-1]};
  assign diff    = shifted - {2'b00, d};

  assign r_out = diff[N+1] ? shifted[N:0] : diff[N:0];
  assign q_out = {q_in[N-2:0], ~diff[N+1]};

endmodule

// File: rtl/div32_seq.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU results.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and |a|<|b| finish at the
// accept edge instead of running the full iteration sequence.
module div32_seq
  import div_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  div32_seq_if.slave  bus
);

  div_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [N:0]   r;
  logic [N-1:0] q;
  logic [N-1:0] b_mag;
  logic [N-1:0] a_orig;
  logic         sign_q;
  logic         sign_r;
  logic         b_zero;

  logic         in_ready_q;
  logic         out_valid_q;
  logic [N-1:0] quo_q;
  logic [N-1:0] rem_q;
  logic         div_zero_q;

  logic         sa;
  logic         sb;
  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;
  logic [N:0]   r_next;
  logic [N-1:0] q_next;
  logic [N-1:0] quo_fix;
  logic [N-1:0] rem_fix;

  assign sa    = bus.is_signed & bus.a[N-1];
  assign sb    = bus.is_signed & bus.b[N-1];
  assign a_abs = sa ? -bus.a : bus.a;
  assign b_abs = sb ? -bus.b : bus.b;

  // Final sign correction; divide-by-zero overrides with the RISC-V values.
  assign quo_fix = b_zero ? '1     : (sign_q ? -q : q);
  assign rem_fix = b_zero ? a_orig : (sign_r ? -r[N-1:0] : r[N-1:0]);

  div_step #(.N(N)) u_step (
    .r_in  (r),
    .q_in  (q),
    .d     (b_mag),
    .r_out (r_next),
    .q_out (q_next)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quo       = quo_q;
  assign bus.rem       = rem_q;
  assign bus.div_zero  = div_zero_q;

  // Control FSM plus datapath registers: accept, iterate, sign-fix, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      b_mag       <= '0;
      a_orig      <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      b_zero      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r          <= '0;
            q          <= a_abs;
            b_mag      <= b_abs;
            a_orig     <= bus.a;
            sign_q     <= sa ^ sb;
            sign_r     <= sa;
            b_zero     <= (bus.b == '0);
            cnt        <= CNT_W'(N);
            in_ready_q <= 1'b0;
            state      <= ST_CALC;
`ifdef DIV_EARLY_OUT_EN
            if ((bus.b == '0) || (a_abs < b_abs)) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              quo_q       <= (bus.b == '0) ? '1 : '0;
              rem_q       <= bus.a;
              div_zero_q  <= (bus.b == '0);
            end
`endif
          end
        end
        ST_CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quo_q       <= quo_fix;
          rem_q       <= rem_fix;
          div_zero_q  <= b_zero;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases, reset in the
// middle of a division, and randomized operations checked against an
// arithmetic reference model. Honors DIV_EARLY_OUT_EN for latency checks.
module tb_div32_seq;
  import div_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [N-1:0] exp_quo;
  logic [N-1:0] exp_rem;
  logic         exp_dz;
  bit           exp_pending = 1'b0;

  div32_seq_if #(.N(N)) bus ();

  div32_seq #(.N(N), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic recordFailure(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // RISC-V division results computed directly from the language's arithmetic.
  function automatic void model(input logic sgn, input logic [N-1:0] a,
                                input logic [N-1:0] b, output logic [N-1:0] q,
                                output logic [N-1:0] r, output logic dz);
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  function automatic logic [N-1:0] mag(input logic sgn, input logic [N-1:0] x);
    return (sgn && x[N-1]) ? -x : x;
  endfunction

  function automatic int expLatency(input logic sgn, input logic [N-1:0] a,
                                    input logic [N-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == '0 || mag(sgn, a) < mag(sgn, b)) return 0;
`endif
    return N + 1;
  endfunction

  function automatic logic [N-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd1;
      default: return 32'($urandom);
    endcase
  endfunction

  // Result checker: whenever a result is presented it must match the model
  // and stay stable for as long as it is held.
  always @(negedge clk) begin
    if (rst_n && exp_pending && bus.out_valid) begin
      checkOutput("quo", bus.quo, exp_quo);
      checkOutput("rem", bus.rem, exp_rem);
      checkOutput("div_zero", 32'(bus.div_zero), 32'(exp_dz));
      checkOutput("in_ready_while_done", 32'(bus.in_ready), 32'd0);
    end
  end

  // Issue one operation, measure its latency, stall the result, then retire it.
  task automatic applyStimulus(input logic sgn, input logic [N-1:0] a,
                               input logic [N-1:0] b, input int hold);
    int waited = 0;
    int edges = 0;
    int lat;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      recordFailure("idle_wait");
      return;
    end
    model(sgn, a, b, exp_quo, exp_rem, exp_dz);
    lat = expLatency(sgn, a, b);
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = 32'($urandom);
    bus.b         = 32'($urandom);
    bus.is_signed = 1'($urandom_range(0, 1));
    exp_pending   = 1'b1;
    checkOutput("busy_in_ready", 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && edges < 100) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      edges++;
    end
    bus.out_ready = 1'b0;
    if (!bus.out_valid) begin
      recordFailure("result_wait");
      exp_pending = 1'b0;
      return;
    end
    checkOutput("latency", 32'(edges), 32'(lat));
    repeat (hold) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_pending   = 1'b0;
    checkOutput("out_valid_after_take", 32'(bus.out_valid), 32'd0);
    checkOutput("in_ready_after_take", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] mq;
    logic [N-1:0] mr;
    logic         mdz;
    logic [1:0]   op;

    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_quo", bus.quo, 32'd0);
    checkOutput("reset_rem", bus.rem, 32'd0);
    checkOutput("reset_div_zero", 32'(bus.div_zero), 32'd0);

    // Hand-computed anchors for the reference model.
    model(1'b0, 32'd100, 32'd7, mq, mr, mdz);
    checkOutput("model_divu_q", mq, 32'd14);
    checkOutput("model_divu_r", mr, 32'd2);
    model(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr, mdz);
    checkOutput("model_div_q", mq, 32'hFFFF_FFFD);
    checkOutput("model_div_r", mr, 32'hFFFF_FFFF);
    model(1'b1, 32'h1234_5678, 32'd0, mq, mr, mdz);
    checkOutput("model_dz_q", mq, 32'hFFFF_FFFF);
    checkOutput("model_dz_r", mr, 32'h1234_5678);
    checkOutput("model_dz_flag", 32'(mdz), 32'd1);
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mq, mr, mdz);
    checkOutput("model_ovf_q", mq, 32'h8000_0000);
    checkOutput("model_ovf_r", mr, 32'd0);

    @(negedge clk);
    applyStimulus(1'b0, 32'd100, 32'd7, 0);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    applyStimulus(1'b1, 32'h1234_5678, 32'd0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'd3, 5);
    applyStimulus(1'b1, 32'd5, 32'hFFFF_FFF0, 2);

    // Reset while iterating: results clear at once, next op unaffected.
    @(negedge clk);
    bus.is_signed = 1'b0;
    bus.a         = 32'd1000;
    bus.b         = 32'd3;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_quo", bus.quo, 32'd0);
    checkOutput("midreset_rem", bus.rem, 32'd0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'd1000, 32'd3, 0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      applyStimulus(op_is_signed(op), pickOperand(), pickOperand(),
                    int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
